// File: rtl/imm_extend_pipe.sv
// Two-stage immediate extender: S1 captures the raw field, S2 holds the
// sign/zero-extended (optionally shifted) result behind a valid/ready handshake.
module imm_extend_pipe #(
    parameter int unsigned IN_W      = 12,
    parameter int unsigned OUT_W     = 16,
    parameter int unsigned NARROW0_W = 4,
    parameter int unsigned NARROW1_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_mode,
    input  logic             in_shl,
    input  logic [IN_W-1:0]  in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic             out_neg
);

    localparam int unsigned PAD0_W = OUT_W - NARROW0_W;
    localparam int unsigned PAD1_W = OUT_W - NARROW1_W;
    localparam int unsigned PADF_W = OUT_W - IN_W;

    generate
        if (!(OUT_W >= IN_W + 1) || !(NARROW0_W < NARROW1_W) || !(NARROW1_W < IN_W)) begin : g_bad_params
            $error("imm_extend_pipe: illegal parameter combination");
        end
    endgenerate

    logic             v1;
    logic             v2;
    logic             adv1;
    logic             adv2;
    logic [1:0]       s1_mode;
    logic             s1_shl;
    logic [IN_W-1:0]  s1_data;
    logic [OUT_W-1:0] ext;
    logic [OUT_W-1:0] res;

    // A stage may load when it is empty or the stage after it is draining.
    always_comb begin
        adv2     = ~v2 | out_ready;
        adv1     = ~v1 | adv2;
        in_ready = adv1;
    end

    // Extension of the S1 field selected by mode, then the optional branch shift.
    always_comb begin
        ext = '0;
        case (s1_mode)
            2'b00: ext = {{PAD0_W{s1_data[NARROW0_W-1]}}, s1_data[NARROW0_W-1:0]};
            2'b01: ext = {{PAD1_W{s1_data[NARROW1_W-1]}}, s1_data[NARROW1_W-1:0]};
            2'b10: ext = {{PADF_W{s1_data[IN_W-1]}}, s1_data};
            2'b11: ext = {{PADF_W{1'b0}}, s1_data};
        endcase
        res = s1_shl ? {ext[OUT_W-2:0], 1'b0} : ext;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            v1      <= 1'b0;
            s1_mode <= 2'b00;
            s1_shl  <= 1'b0;
            s1_data <= '0;
        end else if (adv1) begin
            v1      <= in_valid;
            s1_mode <= in_mode;
            s1_shl  <= in_shl;
            s1_data <= in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            v2       <= 1'b0;
            out_data <= '0;
            out_neg  <= 1'b0;
        end else if (adv2) begin
            v2       <= v1;
            out_data <= res;
            out_neg  <= ext[OUT_W-1];
        end
    end

    assign out_valid = v2;

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Scoreboard bench for imm_extend_pipe: directed vector table, backpressure
// and reset corner sequences, then a randomized valid/ready stream.
module tb_imm_extend_pipe;

    localparam int unsigned IN_W  = 12;
    localparam int unsigned OUT_W = 16;

    logic             clk;
    logic             reset;
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       in_mode;
    logic             in_shl;
    logic [IN_W-1:0]  in_data;
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] out_data;
    logic             out_neg;

    imm_extend_pipe #(.IN_W(12), .OUT_W(16), .NARROW0_W(4), .NARROW1_W(8)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_mode(in_mode), .in_shl(in_shl), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_neg(out_neg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [OUT_W-1:0] data;
        logic             neg;
        int               cyc;
    } sb_t;

    typedef struct {
        logic [1:0]       mode;
        logic             shl;
        logic [IN_W-1:0]  data;
        logic [OUT_W-1:0] exp_data;
        logic             exp_neg;
    } vec_t;

    sb_t sb[$];
    int  checks = 0;
    int  errors = 0;
    int  cyc    = 0;
    bit  lat_chk = 1'b0;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Independent reference: mask field, subtract 2^k when negative, wrap to OUT_W.
    function automatic logic [OUT_W:0] ref_f(input logic [1:0] m, input logic sh, input logic [IN_W-1:0] d);
        int k;
        int v;
        logic ng;
        k = (m == 2'd0) ? 4 : (m == 2'd1) ? 8 : 12;
        v = int'(d) & ((1 << k) - 1);
        if (m != 2'd3 && v >= (1 << (k - 1))) v = v - (1 << k);
        v  = v & 32'h0000_FFFF;
        ng = v[15];
        if (sh) v = (v << 1) & 32'h0000_FFFF;
        return {ng, 16'(v)};
    endfunction

    // One clock: drive at negedge, settle, score transfers, then advance past posedge.
    task automatic cycle(input logic rst, input logic iv, input logic [1:0] md, input logic sh,
                         input logic [IN_W-1:0] d, input logic [OUT_W-1:0] ed, input logic en,
                         input logic ordy, output logic acc);
        sb_t e;
        @(negedge clk);
        reset = rst; in_valid = iv; in_mode = md; in_shl = sh; in_data = d; out_ready = ordy;
        #1;
        acc = 1'b0;
        if (!rst) begin
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL spurious_output: got 0x%0h expected no output", out_data);
                end else begin
                    e = sb.pop_front();
                    chk("out_data", int'(out_data), int'(e.data));
                    chk("out_neg", int'(out_neg), int'(e.neg));
                    if (lat_chk) chk("latency", cyc - e.cyc, 2);
                end
            end
            if (in_valid && in_ready) begin
                e.data = ed; e.neg = en; e.cyc = cyc;
                sb.push_back(e);
                acc = 1'b1;
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    vec_t vt[10];
    logic acc;
    logic [OUT_W:0] r;

    initial begin
        vt[0] = '{2'b00, 1'b0, 12'h1F0, 16'h0000, 1'b0};
        vt[1] = '{2'b01, 1'b0, 12'h1F0, 16'hFFF0, 1'b1};
        vt[2] = '{2'b10, 1'b0, 12'h1F0, 16'h01F0, 1'b0};
        vt[3] = '{2'b11, 1'b0, 12'h1F0, 16'h01F0, 1'b0};
        vt[4] = '{2'b10, 1'b0, 12'h8F0, 16'hF8F0, 1'b1};
        vt[5] = '{2'b11, 1'b0, 12'h8F0, 16'h08F0, 1'b0};
        vt[6] = '{2'b10, 1'b1, 12'h8F0, 16'hF1E0, 1'b1};
        vt[7] = '{2'b10, 1'b1, 12'h07F, 16'h00FE, 1'b0};
        vt[8] = '{2'b00, 1'b1, 12'hFF8, 16'hFFF0, 1'b1};
        vt[9] = '{2'b11, 1'b1, 12'hFFF, 16'h1FFE, 1'b0};

        reset = 1'b1; in_valid = 1'b0; in_mode = 2'b00; in_shl = 1'b0; in_data = '0; out_ready = 1'b0;
        cycle(1'b1, 1'b0, 2'b00, 1'b0, '0, '0, 1'b0, 1'b0, acc);
        cycle(1'b1, 1'b0, 2'b00, 1'b0, '0, '0, 1'b0, 1'b0, acc);
        chk("reset_out_valid", int'(out_valid), 0);
        chk("reset_in_ready", int'(in_ready), 1);
        chk("reset_out_data", int'(out_data), 0);
        chk("reset_out_neg", int'(out_neg), 0);

        // Directed table with continuous ready: one accept per clock, 2-clock latency.
        lat_chk = 1'b1;
        for (int i = 0; i < 10; i++) begin
            cycle(1'b0, 1'b1, vt[i].mode, vt[i].shl, vt[i].data, vt[i].exp_data, vt[i].exp_neg, 1'b1, acc);
            chk("stream_accept", int'(acc), 1);
        end
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 2'b00, 1'b0, '0, '0, 1'b0, 1'b1, acc);
        chk("table_drained", sb.size(), 0);
        lat_chk = 1'b0;

        // Backpressure: five items, sink stalled, then released.
        begin
            logic [IN_W-1:0] bd[5];
            int idx;
            idx = 0;
            for (int i = 0; i < 5; i++) bd[i] = 12'h805 + 12'(i * 12'h111);
            for (int c = 0; c < 6; c++) begin
                r = ref_f(2'b10, 1'b0, bd[idx]);
                cycle(1'b0, 1'b1, 2'b10, 1'b0, bd[idx], r[OUT_W-1:0], r[OUT_W], 1'b0, acc);
                if (acc) idx++;
            end
            r = ref_f(2'b10, 1'b0, bd[0]);
            chk("stall_accepts", idx, 2);
            chk("stall_in_ready", int'(in_ready), 0);
            chk("stall_out_valid", int'(out_valid), 1);
            chk("stall_held_data", int'(out_data), int'(r[OUT_W-1:0]));
            for (int c = 0; c < 40 && (idx < 5 || sb.size() != 0); c++) begin
                if (idx < 5) begin
                    r = ref_f(2'b10, 1'b0, bd[idx]);
                    cycle(1'b0, 1'b1, 2'b10, 1'b0, bd[idx], r[OUT_W-1:0], r[OUT_W], 1'b1, acc);
                    if (acc) idx++;
                end else begin
                    cycle(1'b0, 1'b0, 2'b00, 1'b0, '0, '0, 1'b0, 1'b1, acc);
                end
            end
            chk("bp_all_sent", idx, 5);
            chk("bp_drained", sb.size(), 0);
        end

        // Reset with both stages full: contents are dropped.
        cycle(1'b0, 1'b1, 2'b11, 1'b0, 12'hABC, 16'h0ABC, 1'b0, 1'b0, acc);
        cycle(1'b0, 1'b1, 2'b11, 1'b0, 12'hDEF, 16'h0DEF, 1'b0, 1'b0, acc);
        chk("full_in_ready", int'(in_ready), 0);
        cycle(1'b1, 1'b1, 2'b11, 1'b0, 12'h123, 16'h0123, 1'b0, 1'b1, acc);
        sb.delete();
        chk("rst_full_out_valid", int'(out_valid), 0);
        chk("rst_full_in_ready", int'(in_ready), 1);
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 2'b00, 1'b0, '0, '0, 1'b0, 1'b1, acc);

        // Random stream: dropped items above would surface as spurious outputs here.
        begin
            int sent;
            logic [1:0] m;
            logic sh;
            logic [IN_W-1:0] d;
            logic iv;
            sent = 0;
            m = 2'($urandom); sh = 1'($urandom); d = IN_W'($urandom);
            for (int c = 0; c < 20000 && (sent < 1000 || sb.size() != 0); c++) begin
                iv = (sent < 1000) && ($urandom_range(0, 9) < 7);
                r  = ref_f(m, sh, d);
                cycle(1'b0, iv, m, sh, d, r[OUT_W-1:0], r[OUT_W], 1'($urandom_range(0, 9) < 7), acc);
                if (acc) begin
                    sent++;
                    m = 2'($urandom); sh = 1'($urandom); d = IN_W'($urandom);
                end
            end
            chk("rand_sent", sent, 1000);
            chk("rand_drained", sb.size(), 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
